// File: rtl/sat_pkg.sv
// Shared types and default widths for the clause evaluation pipeline.
package sat_pkg;

  localparam int unsigned DEF_VAR_PER_CLAUSE = 5;
  localparam int unsigned DEF_VARIABLE_W     = 7;
  localparam int unsigned DEF_CNT_W          = 16;
  localparam int unsigned CLAUSE_ID_W        = 16;
  localparam int unsigned STATUS_W           = 2;

  // Result class of one evaluated clause.
  typedef enum logic [STATUS_W-1:0] {
    SAT        = 2'd0,
    UNIT       = 2'd1,
    CONFLICT   = 2'd2,
    UNRESOLVED = 2'd3
  } clause_status_t;

endpackage

// File: rtl/clause_classifier.sv
// Combinational clause classifier: SAT / UNIT / CONFLICT / UNRESOLVED plus
// the implied assignment for a unit clause.
module clause_classifier
  import sat_pkg::*;
#(
  parameter int unsigned VAR_PER_CLAUSE = DEF_VAR_PER_CLAUSE,
  parameter int unsigned VARIABLE_W     = DEF_VARIABLE_W
) (
  input  logic [VAR_PER_CLAUSE-1:0]                 mask,
  input  logic [VAR_PER_CLAUSE-1:0]                 pole,
  input  logic [VAR_PER_CLAUSE-1:0]                 unassign,
  input  logic [VAR_PER_CLAUSE-1:0]                 lit_value,
  input  logic [VAR_PER_CLAUSE-1:0][VARIABLE_W-1:0] var_idx,
  output clause_status_t                            status,
  output logic [VARIABLE_W-1:0]                     implied_var,
  output logic                                      implied_val
);

  logic                  any_sat;
  logic [1:0]            n_open;     // saturates at 2: only 0, 1, many matter
  logic [VARIABLE_W-1:0] open_var;
  logic                  open_pole;

  // Scan literals: detect any satisfied literal and count open ones.
  always_comb begin
    any_sat   = 1'b0;
    n_open    = 2'd0;
    open_var  = '0;
    open_pole = 1'b0;
    for (int i = 0; i < int'(VAR_PER_CLAUSE); i++) begin
      if (mask[i] && !unassign[i] && (lit_value[i] == pole[i])) begin
        any_sat = 1'b1;
      end
      if (mask[i] && unassign[i]) begin
        if (n_open == 2'd0) begin
          open_var  = var_idx[i];
          open_pole = pole[i];
        end
        if (n_open != 2'd2) begin
          n_open = n_open + 2'd1;
        end
      end
    end
  end

  // Map scan results to a class; implied fields are zero unless UNIT.
  always_comb begin
    status      = UNRESOLVED;
    implied_var = '0;
    implied_val = 1'b0;
    if (any_sat) begin
      status = SAT;
    end else if (n_open == 2'd0) begin
      status = CONFLICT;
    end else if (n_open == 2'd1) begin
      status      = UNIT;
      implied_var = open_var;
      implied_val = open_pole;
    end
  end

endmodule

// File: rtl/clause_eval_pipe.sv
// Two-stage clause evaluation pipeline: S1 captures the clause, S2 holds
// the classified result. Valid/ready on both sides, sticky conflict flag
// and saturating UNIT / CONFLICT statistics.
module clause_eval_pipe
  import sat_pkg::*;
#(
  parameter int unsigned VAR_PER_CLAUSE = DEF_VAR_PER_CLAUSE,
  parameter int unsigned VARIABLE_W     = DEF_VARIABLE_W,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [CLAUSE_ID_W-1:0]                    in_clause_id,
  input  logic [VAR_PER_CLAUSE-1:0]                 in_mask,
  input  logic [VAR_PER_CLAUSE-1:0]                 in_pole,
  input  logic [VAR_PER_CLAUSE-1:0]                 in_unassign,
  input  logic [VAR_PER_CLAUSE-1:0]                 in_assign,
  input  logic [VAR_PER_CLAUSE-1:0][VARIABLE_W-1:0] in_var,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [STATUS_W-1:0]                       out_status,
  output logic [CLAUSE_ID_W-1:0]                    out_clause_id,
  output logic [VARIABLE_W-1:0]                     out_implied_var,
  output logic                                      out_implied_val,
  output logic                                      conflict_seen,
  output logic [CNT_W-1:0]                          unit_count,
  output logic [CNT_W-1:0]                          conflict_count
);

  // S1 registers
  logic                                      s1_valid;
  logic [CLAUSE_ID_W-1:0]                    s1_id;
  logic [VAR_PER_CLAUSE-1:0]                 s1_mask;
  logic [VAR_PER_CLAUSE-1:0]                 s1_pole;
  logic [VAR_PER_CLAUSE-1:0]                 s1_unassign;
  logic [VAR_PER_CLAUSE-1:0]                 s1_value;
  logic [VAR_PER_CLAUSE-1:0][VARIABLE_W-1:0] s1_var;

  // Classifier results for the clause in S1
  clause_status_t        cls_status;
  logic [VARIABLE_W-1:0] cls_var;
  logic                  cls_val;

  logic s1_accept;
  logic s2_load;
  logic out_fire;

  // S1 may take a new clause unless both stages are full and the output stalls.
  assign in_ready  = !(s1_valid && out_valid && !out_ready);
  assign s1_accept = in_valid && in_ready;
  assign s2_load   = s1_valid && (!out_valid || out_ready);
  assign out_fire  = out_valid && out_ready;

  clause_classifier #(
    .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
    .VARIABLE_W     (VARIABLE_W)
  ) u_classifier (
    .mask        (s1_mask),
    .pole        (s1_pole),
    .unassign    (s1_unassign),
    .lit_value   (s1_value),
    .var_idx     (s1_var),
    .status      (cls_status),
    .implied_var (cls_var),
    .implied_val (cls_val)
  );

  // Stage 1: capture an accepted clause; drain when it moves on to S2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      s1_mask     <= '0;
      s1_pole     <= '0;
      s1_unassign <= '0;
      s1_value    <= '0;
      s1_var      <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_accept && !flush) begin
        s1_id       <= in_clause_id;
        s1_mask     <= in_mask;
        s1_pole     <= in_pole;
        s1_unassign <= in_unassign;
        s1_value    <= in_assign;
        s1_var      <= in_var;
      end
    end
  end

  // Stage 2: hold the classified result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_status      <= '0;
      out_clause_id   <= '0;
      out_implied_var <= '0;
      out_implied_val <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_load) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (s2_load && !flush) begin
        out_status      <= STATUS_W'(cls_status);
        out_clause_id   <= s1_id;
        out_implied_var <= cls_var;
        out_implied_val <= cls_val;
      end
    end
  end

  // Statistics and sticky flag; flush clears the flag but keeps the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_seen  <= 1'b0;
      unit_count     <= '0;
      conflict_count <= '0;
    end else begin
      if (flush) begin
        conflict_seen <= 1'b0;
      end else if (out_fire && (out_status == STATUS_W'(CONFLICT))) begin
        conflict_seen <= 1'b1;
      end
      if (out_fire && (out_status == STATUS_W'(UNIT)) && (unit_count != '1)) begin
        unit_count <= unit_count + CNT_W'(1);
      end
      if (out_fire && (out_status == STATUS_W'(CONFLICT)) && (conflict_count != '1)) begin
        conflict_count <= conflict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clause_eval_pipe.sv
// Directed bench for clause_eval_pipe: a default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_clause_eval_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic out_ready;
  logic [15:0] in_clause_id;
  logic [4:0]  in_mask, in_pole, in_unassign, in_assign;
  logic [4:0][6:0] in_var;

  logic        in_ready, out_valid, out_implied_val, conflict_seen;
  logic [1:0]  out_status;
  logic [15:0] out_clause_id, unit_count, conflict_count;
  logic [6:0]  out_implied_var;

  logic        s_in_ready, s_out_valid, s_out_implied_val, s_conflict_seen;
  logic [1:0]  s_out_status, s_unit_count, s_conflict_count;
  logic [15:0] s_out_clause_id;
  logic [6:0]  s_out_implied_var;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_unit = 16'd0;
  logic [15:0] exp_conf = 16'd0;

  always #5 clk = ~clk;

  clause_eval_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_clause_id(in_clause_id), .in_mask(in_mask), .in_pole(in_pole),
    .in_unassign(in_unassign), .in_assign(in_assign), .in_var(in_var),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
    .out_clause_id(out_clause_id), .out_implied_var(out_implied_var),
    .out_implied_val(out_implied_val), .conflict_seen(conflict_seen),
    .unit_count(unit_count), .conflict_count(conflict_count)
  );

  clause_eval_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_clause_id(in_clause_id), .in_mask(in_mask), .in_pole(in_pole),
    .in_unassign(in_unassign), .in_assign(in_assign), .in_var(in_var),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_status(s_out_status),
    .out_clause_id(s_out_clause_id), .out_implied_var(s_out_implied_var),
    .out_implied_val(s_out_implied_val), .conflict_seen(s_conflict_seen),
    .unit_count(s_unit_count), .conflict_count(s_conflict_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_clause(input logic [15:0] id, input logic [4:0] m, input logic [4:0] u,
                            input logic [4:0] a, input logic [4:0] p);
    in_clause_id = id;
    in_mask      = m;
    in_unassign  = u;
    in_assign    = a;
    in_pole      = p;
  endtask

  // Send one clause with out_ready high and check the result and 2-cycle latency.
  task automatic run_single(input string name, input logic [1:0] st, input logic [6:0] iv,
                            input logic ival);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready); end
    checks++;
    tick();
    in_valid = 1'b0;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid: got %b expected 0", name, out_valid); end
    checks++;
    tick();
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b expected 1", name, out_valid); end
    checks++;
    if (out_status !== st) begin errors++; $display("FAIL %s status: got %0d expected %0d", name, out_status, st); end
    checks++;
    if (out_clause_id !== in_clause_id) begin errors++; $display("FAIL %s id: got %h expected %h", name, out_clause_id, in_clause_id); end
    checks++;
    if (out_implied_var !== iv || out_implied_val !== ival) begin
      errors++;
      $display("FAIL %s implied: got var=%0d val=%b expected var=%0d val=%b", name, out_implied_var, out_implied_val, iv, ival);
    end
    checks++;
    tick();
    if (st == 2'd1) exp_unit++;
    if (st == 2'd2) exp_conf++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_var = '0;
    set_clause(16'h0, 5'b0, 5'b0, 5'b0, 5'b0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    if (out_valid !== 1'b0 || out_status !== 2'd0 || out_clause_id !== 16'h0 ||
        out_implied_var !== 7'd0 || out_implied_val !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b status=%0d id=%h expected zeros", out_valid, out_status, out_clause_id);
    end
    checks++;
    if (unit_count !== 16'd0 || conflict_count !== 16'd0 || conflict_seen !== 1'b0) begin
      errors++; $display("FAIL reset_stats: got unit=%0d conf=%0d seen=%b expected 0", unit_count, conflict_count, conflict_seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
  endtask

  task automatic test_sat();
    set_clause(16'h0001, 5'b11111, 5'b00000, 5'b10000, 5'b10000);
    run_single("sat", 2'd0, 7'd0, 1'b0);
  endtask

  task automatic test_unit();
    in_var = '0;
    in_var[2] = 7'd42;
    set_clause(16'h0002, 5'b00111, 5'b00100, 5'b00000, 5'b00011);
    run_single("unit", 2'd1, 7'd42, 1'b0);
    if (unit_count !== exp_unit) begin errors++; $display("FAIL unit_count: got %0d expected %0d", unit_count, exp_unit); end
    checks++;
    in_var = '0;
  endtask

  task automatic test_conflict_flush();
    set_clause(16'h0003, 5'b00111, 5'b00000, 5'b00000, 5'b00111);
    run_single("conflict", 2'd2, 7'd0, 1'b0);
    if (conflict_seen !== 1'b1) begin errors++; $display("FAIL conflict_seen_set: got %b expected 1", conflict_seen); end
    checks++;
    // Flush with a clause offered in the same cycle: the clause must be dropped.
    set_clause(16'h0077, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    if (conflict_seen !== 1'b0 || conflict_count !== exp_conf) begin
      errors++; $display("FAIL flush_clear: got seen=%b count=%0d expected seen=0 count=%0d", conflict_seen, conflict_count, exp_conf);
    end
    checks++;
    tick(); tick(); tick();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got out_valid=%b expected 0", out_valid); end
    checks++;
    // Flush coincident with a CONFLICT handshake: flag stays clear, count still moves.
    set_clause(16'h0004, 5'b00011, 5'b00000, 5'b00011, 5'b00000);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    if (out_valid !== 1'b1 || out_status !== 2'd2) begin
      errors++; $display("FAIL flush_race_pre: got valid=%b status=%0d expected 1/2", out_valid, out_status);
    end
    checks++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_conf++;
    if (conflict_seen !== 1'b0 || conflict_count !== exp_conf || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_race: got seen=%b count=%0d valid=%b expected 0/%0d/0", conflict_seen, conflict_count, out_valid, exp_conf);
    end
    checks++;
  endtask

  task automatic test_empty_and_open();
    set_clause(16'h0005, 5'b00000, 5'b11111, 5'b11111, 5'b11111);
    run_single("empty", 2'd2, 7'd0, 1'b0);
    if (conflict_count !== exp_conf || conflict_seen !== 1'b1) begin
      errors++; $display("FAIL empty_stats: got count=%0d seen=%b expected %0d/1", conflict_count, conflict_seen, exp_conf);
    end
    checks++;
    in_var[0] = 7'd3; in_var[1] = 7'd5;
    set_clause(16'h0006, 5'b00011, 5'b00011, 5'b00000, 5'b00011);
    run_single("two_open", 2'd3, 7'd0, 1'b0);
    in_var = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] exp_id;
    logic [15:0] h_id;
    logic [1:0]  h_st;
    logic [1:0]  exp_st;
    int sent = 0;
    int recv = 0;
    bit dropped = 1'b0;
    bit hold = 1'b0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      if ((sent % 2) == 1) set_clause(16'h0100 + 16'(sent), 5'b00011, 5'b00011, 5'b00000, 5'b00011);
      else                 set_clause(16'h0100 + 16'(sent), 5'b00001, 5'b00000, 5'b00001, 5'b00001);
      #1;
      if (hold) begin
        if (out_valid !== 1'b1 || out_clause_id !== h_id || out_status !== h_st) begin
          errors++; $display("FAIL b2b_hold: got valid=%b id=%h st=%0d expected 1/%h/%0d", out_valid, out_clause_id, out_status, h_id, h_st);
        end
        checks++;
      end
      if (in_valid && !in_ready) dropped = 1'b1;
      if (in_valid && in_ready) begin exp_q.push_back(in_clause_id); sent++; end
      if (out_valid && out_ready) begin
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
        exp_st = exp_id[0] ? 2'd3 : 2'd0;
        if (out_clause_id !== exp_id || out_status !== exp_st) begin
          errors++; $display("FAIL b2b_order: got id=%h st=%0d expected %h/%0d", out_clause_id, out_status, exp_id, exp_st);
        end
        checks++;
        recv++;
      end
      hold = out_valid && !out_ready;
      h_id = out_clause_id;
      h_st = out_status;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (recv != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got recv=%0d pending=%0d expected 8/0", recv, exp_q.size());
    end
    checks++;
    if (!dropped) begin errors++; $display("FAIL b2b_backpressure: got in_ready never low expected a drop"); end
    checks++;
    tick(); tick();
    if (out_valid !== 1'b0 || unit_count !== exp_unit) begin
      errors++; $display("FAIL b2b_drain: got valid=%b unit=%0d expected 0/%0d", out_valid, unit_count, exp_unit);
    end
    checks++;
  endtask

  task automatic test_saturate_and_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_unit = 16'd0; exp_conf = 16'd0;
    if (s_unit_count !== 2'd0 || unit_count !== 16'd0) begin
      errors++; $display("FAIL sat_reset: got small=%0d wide=%0d expected 0/0", s_unit_count, unit_count);
    end
    checks++;
    in_var = '0; in_var[0] = 7'd9;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_clause(16'h0200 + 16'(k), 5'b00001, 5'b00001, 5'b00000, 5'b00001);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    if (s_unit_count !== 2'd3) begin errors++; $display("FAIL sat_small: got %0d expected 3", s_unit_count); end
    checks++;
    if (unit_count !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d expected 5", unit_count); end
    checks++;
    // Reset mid-stream: in-flight clauses vanish without reaching the output.
    set_clause(16'h0300, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
    in_valid = 1'b1;
    tick();
    in_clause_id = 16'h0301;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_clause_id !== 16'h0) begin
      errors++; $display("FAIL midreset: got valid=%b ready=%b id=%h expected 0/1/0", out_valid, in_ready, out_clause_id);
    end
    checks++;
    tick(); tick(); tick();
    if (out_valid !== 1'b0 || s_out_valid !== 1'b0 || unit_count !== 16'd0) begin
      errors++; $display("FAIL midreset_residual: got valid=%b small=%b unit=%0d expected 0/0/0", out_valid, s_out_valid, unit_count);
    end
    checks++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sat();
    test_unit();
    test_conflict_flush();
    test_empty_and_open();
    test_back_to_back();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
